scan_halver_ctrl: RTL and testbench

- Sequences the shared single-port-per-side scanline buffer (dual-port RAM, 2 banks × 2^ADDR_W entries) that sits between the Williams core's native video output and video_mixer.
- Generates write addresses/enables from the core's pixel strobe and syncs, ping-pong bank selection, and read addresses with the output pixel strobe.
- Regenerates HSync/HBlank/VSync/VBlank for the halved-rate output.
- Runs entirely in clk_sys; the core's pixel strobe and syncs arrive as clk_sys-sampled signals.

---
 rtl/scan_halver_ctrl.sv | 140 ++++++++++++++
 tb/tb_scan_halver_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_halver_ctrl.sv
// Scanline buffer sequencer: stores every other source line into a ping-pong bank
// and replays it at the halved output pixel rate with regenerated video timing.
module scan_halver_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int DIV_W       = 2,
  parameter int LINE_W      = 11,
  parameter int H_BLANK_ON  = 348,
  parameter int H_SYNC_ON   = 370,
  parameter int H_SYNC_OFF  = 14,
  parameter int H_BLANK_OFF = 52,
  parameter int V_BLANK_ON  = 494,
  parameter int V_SYNC_ON   = 496,
  parameter int V_SYNC_OFF  = 0,
  parameter int V_BLANK_OFF = 14
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              pix_ce,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_bank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank,
  output logic              ce_out,
  output logic [LINE_W-1:0] line,
  output logic              HSync,
  output logic              HBlank,
  output logic              VSync,
  output logic              VBlank
);

  localparam int CNT_W = ADDR_W + DIV_W;

  logic              hs_p0, hs_p1, vs_p0, vs_p1;
  logic              hs_fall, vs_fall;
  logic              gate_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [LINE_W-1:0] line_p1;
  logic [CNT_W-1:0]  rd_cnt_p1;
  logic [CNT_W-1:0]  rd_cnt_nxt;

  // Set/clear flag update; a simultaneous clear dominates.
  function automatic logic next_level(input logic cur, input logic set, input logic clr);
    if (clr) return 1'b0;
    if (set) return 1'b1;
    return cur;
  endfunction

  // Stage p0/p1: sync history for edge detection
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      hs_p0 <= 1'b0;
      hs_p1 <= 1'b0;
      vs_p0 <= 1'b0;
      vs_p1 <= 1'b0;
    end else begin
      hs_p0 <= hs_in;
      hs_p1 <= hs_p0;
      vs_p0 <= vs_in;
      vs_p1 <= vs_p0;
    end
  end

  assign hs_fall = hs_p1 & ~hs_p0;
  assign vs_fall = vs_p1 & ~vs_p0;

  // Stage p1: input line counter, frame start wins over line start
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      line_p1 <= '0;
    end else if (hs_fall) begin
      if (vs_fall)
        line_p1 <= '0;
      else if (line_p1 != '1)
        line_p1 <= line_p1 + LINE_W'(1);
    end
  end

  // Stage p1: write address and gate; a strobe on the line-start cycle lands at address 0
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      wr_addr_p1 <= '0;
      gate_p1    <= 1'b0;
    end else if (hs_fall) begin
      wr_addr_p1 <= {{(ADDR_W-1){1'b0}}, pix_ce};
      gate_p1    <= 1'b1;
    end else if (pix_ce) begin
      if (wr_addr_p1 == '1)
        gate_p1 <= 1'b0;
      else
        wr_addr_p1 <= wr_addr_p1 + ADDR_W'(1);
    end
  end

  assign wr_addr = hs_fall ? '0 : wr_addr_p1;
  assign wr_en   = pix_ce & (gate_p1 | hs_fall) & ~line_p1[0];
  assign wr_bank = line_p1[1];
  assign rd_bank = ~line_p1[1];
  assign line    = line_p1;

  // Output line restarts only at the end of an odd input line
  always_comb begin
    rd_cnt_nxt = rd_cnt_p1;
    if (hs_fall && line_p1[0])
      rd_cnt_nxt = '0;
    else if (rd_cnt_p1 != '1)
      rd_cnt_nxt = rd_cnt_p1 + CNT_W'(1);
  end

  // Stage p1: read counter and output pixel strobe
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      rd_cnt_p1 <= '0;
      ce_out    <= 1'b0;
    end else begin
      rd_cnt_p1 <= rd_cnt_nxt;
      ce_out    <= (rd_cnt_nxt[DIV_W-1:0] == '0);
    end
  end

  assign rd_addr = rd_cnt_p1[CNT_W-1:DIV_W];

  // Stage p2: timing flags registered one cycle after their compare
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      HBlank <= 1'b0;
      HSync  <= 1'b0;
      VBlank <= 1'b0;
      VSync  <= 1'b0;
    end else begin
      HBlank <= next_level(HBlank, rd_addr == ADDR_W'(H_BLANK_ON), rd_addr == ADDR_W'(H_BLANK_OFF));
      HSync  <= next_level(HSync,  rd_addr == ADDR_W'(H_SYNC_ON),  rd_addr == ADDR_W'(H_SYNC_OFF));
      VBlank <= next_level(VBlank, line_p1 == LINE_W'(V_BLANK_ON), line_p1 == LINE_W'(V_BLANK_OFF));
      VSync  <= next_level(VSync,  line_p1 == LINE_W'(V_SYNC_ON),  line_p1 == LINE_W'(V_SYNC_OFF));
    end
  end

endmodule

// File: tb/tb_scan_halver_ctrl.sv
// Bench for scan_halver_ctrl: directed scenarios plus randomized sync/strobe
// traffic compared against an event-level reference model.
module tb_scan_halver_ctrl;
  localparam int ADDR_W = 10;
  localparam int LINE_W = 11;

  logic              clk_sys = 1'b0;
  logic              RESET;
  logic              pix_ce, hs_in, vs_in;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_bank, wr_en, rd_bank, ce_out;
  logic [LINE_W-1:0] line;
  logic              HSync, HBlank, VSync, VBlank;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_line, m_wa, m_rc;
  bit m_gate, m_ce, m_hb, m_hs, m_vb, m_vs;
  bit h_d1, h_d2, v_d1, v_d2;
  bit cur_p, cur_h, cur_v, m_hf, m_vf;
  int e_wa;
  bit e_we;

  always #5 clk_sys = ~clk_sys;

  scan_halver_ctrl dut (
    .clk_sys(clk_sys), .RESET(RESET), .pix_ce(pix_ce), .hs_in(hs_in), .vs_in(vs_in),
    .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_en(wr_en), .rd_addr(rd_addr),
    .rd_bank(rd_bank), .ce_out(ce_out), .line(line), .HSync(HSync), .HBlank(HBlank),
    .VSync(VSync), .VBlank(VBlank)
  );

  task automatic model_clear();
    m_line = 0; m_wa = 0; m_rc = 0;
    m_gate = 0; m_ce = 0; m_hb = 0; m_hs = 0; m_vb = 0; m_vs = 0;
    h_d1 = 0; h_d2 = 0; v_d1 = 0; v_d2 = 0;
  endtask

  // Called at a falling edge: apply inputs and derive this cycle's expected write side.
  task automatic drive(input bit p, input bit h, input bit v);
    pix_ce = p; hs_in = h; vs_in = v;
    cur_p = p; cur_h = h; cur_v = v;
    m_hf = h_d2 && !h_d1;
    m_vf = v_d2 && !v_d1;
    e_wa = m_hf ? 0 : m_wa;
    e_we = p && (m_gate || m_hf) && (m_line % 2 == 0);
    #1;
  endtask

  // Advance the model across the coming rising edge, then wait for the next falling edge.
  task automatic tick();
    int ra;
    ra = m_rc / 4;
    if (ra == 52) m_hb = 0; else if (ra == 348) m_hb = 1;
    if (ra == 14) m_hs = 0; else if (ra == 370) m_hs = 1;
    if (m_line == 14) m_vb = 0; else if (m_line == 494) m_vb = 1;
    if (m_line == 0) m_vs = 0; else if (m_line == 496) m_vs = 1;
    if (m_hf && (m_line % 2 == 1)) m_rc = 0;
    else if (m_rc < 4095) m_rc = m_rc + 1;
    m_ce = (m_rc % 4 == 0);
    if (m_hf) begin
      m_gate = 1;
      m_wa = cur_p ? 1 : 0;
    end else if (cur_p) begin
      if (m_wa == 1023) m_gate = 0;
      else m_wa = m_wa + 1;
    end
    if (m_hf) m_line = m_vf ? 0 : ((m_line < 2047) ? m_line + 1 : 2047);
    h_d2 = h_d1; h_d1 = cur_h;
    v_d2 = v_d1; v_d1 = cur_v;
    @(negedge clk_sys);
  endtask

  task automatic cyc(input bit p, input bit h, input bit v);
    drive(p, h, v);
    tick();
  endtask

  task automatic new_line(input bit with_vs);
    repeat (2) cyc(1'b0, 1'b1, with_vs);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    new_line(1'b0);
    repeat (200) cyc(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (wr_addr !== 10'd200) begin errors++; $display("FAIL pre_reset_wr_addr: got %0d expected 200", wr_addr); end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({wr_addr, rd_addr, line} !== '0) begin
      errors++; $display("FAIL reset_counters: wr_addr %0d rd_addr %0d line %0d expected all 0", wr_addr, rd_addr, line);
    end
    checks++;
    if ({wr_en, wr_bank, ce_out, HSync, HBlank, VSync, VBlank} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000000", {wr_en, wr_bank, ce_out, HSync, HBlank, VSync, VBlank});
    end
    checks++;
    if (rd_bank !== 1'b1) begin errors++; $display("FAIL reset_rd_bank: got %b expected 1", rd_bank); end
    repeat (2) @(negedge clk_sys);
    RESET = 1'b0;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (wr_en !== 1'b0) begin errors++; $display("FAIL post_reset_wr_en: strobe %0d got %b expected 0", k, wr_en); end
      tick();
    end
  endtask

  task automatic test_even_write();
    while (m_line != 4) new_line(1'b0);
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(k)) begin
        errors++; $display("FAIL even_write: strobe %0d got wr_en %b addr %0d expected 1 addr %0d", k, wr_en, wr_addr, k);
      end
      checks++;
      if (wr_bank !== 1'b0 || rd_bank !== 1'b1) begin
        errors++; $display("FAIL even_banks: got wr_bank %b rd_bank %b expected 0 1", wr_bank, rd_bank);
      end
      tick();
    end
    new_line(1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (wr_en !== 1'b0) begin errors++; $display("FAIL odd_no_write: strobe %0d got %b expected 0", k, wr_en); end
      tick();
    end
  endtask

  task automatic test_read();
    int c;
    while (m_line != 7) new_line(1'b0);
    new_line(1'b0);
    for (c = 0; c < 9; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (ce_out !== (c % 4 == 0) || rd_addr !== ADDR_W'(c / 4)) begin
        errors++; $display("FAIL read_halving: cycle %0d got ce %b addr %0d expected ce %b addr %0d", c, ce_out, rd_addr, (c % 4 == 0), c / 4);
      end
      tick();
    end
    new_line(1'b0);
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (rd_addr !== ADDR_W'((c + 4) / 4) || ce_out !== 1'b0) begin
      errors++; $display("FAIL even_no_restart: got addr %0d ce %b expected addr %0d ce 0", rd_addr, ce_out, (c + 4) / 4);
    end
    tick();
  endtask

  task automatic test_saturation();
    if (m_line % 2 == 0) new_line(1'b0);
    new_line(1'b0);
    for (int k = 1; k <= 1030; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (wr_en !== (k <= 1024) || wr_addr !== ADDR_W'((k - 1 < 1023) ? k - 1 : 1023)) begin
        errors++; $display("FAIL wr_saturation: strobe %0d got wr_en %b addr %0d", k, wr_en, wr_addr);
      end
      tick();
    end
    new_line(1'b0);
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (wr_addr !== '0) begin errors++; $display("FAIL wr_restart: got %0d expected 0", wr_addr); end
    tick();
  endtask

  task automatic test_random();
    int n, len;
    bit with_vs, mid_vs, h, v;
    n = 0;
    while (n < 3000) begin
      len = $urandom_range(40, 140);
      with_vs = ($urandom_range(0, 7) == 0);
      mid_vs = ($urandom_range(0, 7) == 0);
      for (int pos = 0; pos < len; pos++) begin
        h = (pos >= len - 6);
        v = (with_vs && h) || (mid_vs && pos >= 10 && pos < 13);
        drive($urandom_range(0, 1) == 1, h, v);
        checks++;
        if (wr_en !== e_we) begin errors++; $display("FAIL rnd_wr_en: cyc %0d got %b expected %b", n, wr_en, e_we); end
        checks++;
        if (wr_addr !== ADDR_W'(e_wa)) begin errors++; $display("FAIL rnd_wr_addr: cyc %0d got %0d expected %0d", n, wr_addr, e_wa); end
        checks++;
        if (wr_bank !== m_line[1] || rd_bank !== !m_line[1]) begin
          errors++; $display("FAIL rnd_banks: cyc %0d got %b%b line %0d", n, wr_bank, rd_bank, m_line);
        end
        checks++;
        if (rd_addr !== ADDR_W'(m_rc / 4)) begin errors++; $display("FAIL rnd_rd_addr: cyc %0d got %0d expected %0d", n, rd_addr, m_rc / 4); end
        checks++;
        if (ce_out !== m_ce) begin errors++; $display("FAIL rnd_ce_out: cyc %0d got %b expected %b", n, ce_out, m_ce); end
        checks++;
        if (line !== LINE_W'(m_line)) begin errors++; $display("FAIL rnd_line: cyc %0d got %0d expected %0d", n, line, m_line); end
        checks++;
        if ({HBlank, HSync, VBlank, VSync} !== {m_hb, m_hs, m_vb, m_vs}) begin
          errors++; $display("FAIL rnd_timing: cyc %0d got %b expected %b", n, {HBlank, HSync, VBlank, VSync}, {m_hb, m_hs, m_vb, m_vs});
        end
        tick();
        n++;
      end
    end
  endtask

  task automatic test_h_timing();
    int hb_edge, hs_edge;
    bit hb_prev, hs_prev;
    if (m_line % 2 == 0) new_line(1'b0);
    new_line(1'b0);
    hb_edge = -1; hs_edge = -1;
    hb_prev = HBlank; hs_prev = HSync;
    for (int c = 0; c < 1600; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (HBlank && !hb_prev && hb_edge < 0) hb_edge = c;
      if (HSync && !hs_prev && hs_edge < 0) hs_edge = c;
      hb_prev = HBlank; hs_prev = HSync;
      checks++;
      if ({HBlank, HSync} !== {m_hb, m_hs}) begin
        errors++; $display("FAIL h_model: cycle %0d got %b expected %b", c, {HBlank, HSync}, {m_hb, m_hs});
      end
      tick();
    end
    checks++;
    if (hb_edge != 348 * 4 + 1) begin errors++; $display("FAIL hblank_rise: got cycle %0d expected %0d", hb_edge, 348 * 4 + 1); end
    checks++;
    if (hs_edge != 370 * 4 + 1) begin errors++; $display("FAIL hsync_rise: got cycle %0d expected %0d", hs_edge, 370 * 4 + 1); end
    new_line(1'b0);
    new_line(1'b0);
    hb_edge = -1; hs_edge = -1;
    hb_prev = HBlank; hs_prev = HSync;
    for (int c = 0; c < 250; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (!HBlank && hb_prev && hb_edge < 0) hb_edge = c;
      if (!HSync && hs_prev && hs_edge < 0) hs_edge = c;
      hb_prev = HBlank; hs_prev = HSync;
      tick();
    end
    checks++;
    if (hs_edge != 14 * 4 + 1) begin errors++; $display("FAIL hsync_fall: got cycle %0d expected %0d", hs_edge, 14 * 4 + 1); end
    checks++;
    if (hb_edge != 52 * 4 + 1) begin errors++; $display("FAIL hblank_fall: got cycle %0d expected %0d", hb_edge, 52 * 4 + 1); end
  endtask

  task automatic test_v_timing();
    if (m_line > 493) new_line(1'b1);
    while (m_line < 520) begin
      new_line(1'b0);
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if ({VBlank, VSync} !== {m_vb, m_vs}) begin
        errors++; $display("FAIL v_model: line %0d got %b expected %b", m_line, {VBlank, VSync}, {m_vb, m_vs});
      end
      if (m_line == 494 || m_line == 495) begin
        checks++;
        if (VBlank !== (m_line == 495)) begin errors++; $display("FAIL vblank_set: line %0d got %b", m_line, VBlank); end
      end
      if (m_line == 496 || m_line == 497) begin
        checks++;
        if (VSync !== (m_line == 497)) begin errors++; $display("FAIL vsync_set: line %0d got %b", m_line, VSync); end
      end
      tick();
    end
    new_line(1'b1);
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (line !== '0 || VSync !== 1'b1) begin
      errors++; $display("FAIL sync_priority: got line %0d vsync %b expected line 0 vsync 1", line, VSync);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (VSync !== 1'b0 || VBlank !== 1'b1) begin
      errors++; $display("FAIL vsync_clear: got vsync %b vblank %b expected 0 1", VSync, VBlank);
    end
    tick();
    while (m_line < 15) new_line(1'b0);
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (VBlank !== 1'b0 || line !== 11'd15) begin
      errors++; $display("FAIL vblank_clear: got vblank %b line %0d expected 0 15", VBlank, line);
    end
    tick();
  endtask

  initial begin
    RESET = 1'b1; pix_ce = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    model_clear();
    repeat (2) @(negedge clk_sys);
    RESET = 1'b0;
    test_reset();
    test_even_write();
    test_read();
    test_saturation();
    test_random();
    test_h_timing();
    test_v_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
